uop_decode_queue: RTL and testbench



---
 rtl/uop_decode_queue_pkg.sv | 111 +++++++++++
 rtl/uop_decode_queue_if.sv | 39 +++
 rtl/uop_decode_queue_decode.sv | 194 +++++++++++++++++++
 rtl/uop_decode_queue.sv | 124 ++++++++++++
 tb/tb_uop_decode_queue.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uop_decode_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uop_decode_queue_pkg
//  Purpose  : Shared definitions for the uop decode queue. This package holds
//             the uop bundle layout (UOP_W and the field order), the ALU_OP
//             one-hot codes, the operand-select codes, the MIPS32 opcode and
//             func constants, and the FSM state encoding.
//  Revision : 1.0  initial release
// ============================================================================
package uop_decode_queue_pkg;

    // ALU_OP one-hot encoding
    localparam logic [11:0] ALU_ADD  = 12'h001;
    localparam logic [11:0] ALU_SUB  = 12'h002;
    localparam logic [11:0] ALU_SLT  = 12'h004;
    localparam logic [11:0] ALU_SLTU = 12'h008;
    localparam logic [11:0] ALU_AND  = 12'h010;
    localparam logic [11:0] ALU_NOR  = 12'h020;
    localparam logic [11:0] ALU_OR   = 12'h040;
    localparam logic [11:0] ALU_XOR  = 12'h080;
    localparam logic [11:0] ALU_SLL  = 12'h100;
    localparam logic [11:0] ALU_SRL  = 12'h200;
    localparam logic [11:0] ALU_SRA  = 12'h400;
    localparam logic [11:0] ALU_LUI  = 12'h800;

    // Operand selects
    localparam logic [1:0] SRC1_RS   = 2'd0;
    localparam logic [1:0] SRC1_PC   = 2'd1;
    localparam logic [1:0] SRC1_SA   = 2'd2;
    localparam logic [1:0] SRC2_RT   = 2'd0;
    localparam logic [1:0] SRC2_SIMM = 2'd1;
    localparam logic [1:0] SRC2_ZIMM = 2'd2;
    localparam logic [1:0] SRC2_C8   = 2'd3;   // link address = PC + 8

    // Major opcodes
    localparam logic [5:0] OP_SPECIAL  = 6'b000000;
    localparam logic [5:0] OP_REGIMM   = 6'b000001;
    localparam logic [5:0] OP_J        = 6'b000010;
    localparam logic [5:0] OP_JAL      = 6'b000011;
    localparam logic [5:0] OP_COP0     = 6'b010000;
    localparam logic [5:0] OP_SPECIAL2 = 6'b011100;

    // SPECIAL / SPECIAL2 func codes
    localparam logic [5:0] FN_SLL  = 6'b000000, FN_SRL   = 6'b000010, FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_SLLV = 6'b000100, FN_SRLV  = 6'b000110, FN_SRAV = 6'b000111;
    localparam logic [5:0] FN_JR   = 6'b001000, FN_JALR  = 6'b001001;
    localparam logic [5:0] FN_SYSCALL = 6'b001100, FN_BREAK = 6'b001101;
    localparam logic [5:0] FN_MFHI = 6'b010000, FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO = 6'b010010, FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT = 6'b011000, FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV  = 6'b011010, FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_ADD  = 6'b100000, FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010, FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100, FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110, FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010, FN_SLTU  = 6'b101011;
    localparam logic [5:0] FN_MUL  = 6'b000010;   // under SPECIAL2

    // CP0 CO-format func codes
    localparam logic [5:0] FN_TLBR = 6'b000001, FN_TLBWI = 6'b000010;
    localparam logic [5:0] FN_TLBP = 6'b001000, FN_ERET  = 6'b011000;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CRACK = 1'b1
    } state_t;

    // Uop bundle, MSB first. imm carries the raw instruction bits [25:0]
    // (immediate, shift amount and jump target all live in there).
    typedef struct packed {
        logic [11:0] alu_op;
        logic [1:0]  src1_sel;
        logic [1:0]  src2_sel;
        logic [4:0]  dest;
        logic        reg_write;
        logic [1:0]  mem_size;      // 0 byte, 1 half, 3 word
        logic        mem_sign;
        logic        mem_wl;
        logic        mem_wr;
        logic        mem_en;
        logic        mem_wen;
        logic        hi_we;
        logic        lo_we;
        logic        rd_hi;
        logic        rd_lo;
        logic        mul_en;
        logic        div_en;
        logic        md_signed;
        logic        is_result_product;
        logic        is_branch;
        logic [2:0]  br_cond;       // 0 EQ,1 NE,2 LEZ,3 GTZ,4 LTZ,5 GEZ
        logic        is_jump;
        logic        is_jr;
        logic        cp0_mtc0;
        logic        cp0_mfc0;
        logic        eret;
        logic        tlbp;
        logic        tlbwi;
        logic        tlbr;
        logic [7:0]  cp0_addr;      // {rd, sel}
        logic        overflow_en;
        logic        exc_syscall;
        logic        exc_break;
        logic        exc_reserved;
        logic [25:0] imm;
    } uop_t;

    localparam int UOP_W = $bits(uop_t);

endpackage
`default_nettype wire

// File: rtl/uop_decode_queue_if.sv
`default_nettype none
// ============================================================================
//  Module   : uop_decode_queue_if
//  Purpose  : Handshake bundle of the uop decode queue.
//             Input side : in_valid/in_ready, in_inst, in_pc
//             Output side: out_valid/out_ready, out_uop, out_pc, out_last,
//                          out_count
//             slave  modport - the queue itself
//             master modport - the fetch producer / issue consumer
//  Revision : 1.0  initial release
// ============================================================================
interface uop_decode_queue_if
    import uop_decode_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
);
    logic                   in_valid;
    logic                   in_ready;
    logic [31:0]            in_inst;
    logic [PC_W-1:0]        in_pc;
    logic                   out_valid;
    logic                   out_ready;
    logic [UOP_W-1:0]       out_uop;
    logic [PC_W-1:0]        out_pc;
    logic                   out_last;
    logic [$clog2(DEPTH):0] out_count;

    modport slave (
        input  in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_uop, out_pc, out_last, out_count
    );

    modport master (
        output in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_uop, out_pc, out_last, out_count
    );
endinterface
`default_nettype wire

// File: rtl/uop_decode_queue_decode.sv
`default_nettype none
// ============================================================================
//  Module   : uop_decode
//  Purpose  : Purely combinational MIPS32 instruction -> uop decoder.
//             i_inst        : instruction word
//             o_uop0        : first (usually only) uop
//             o_uop1        : second uop of a cracked instruction
//             o_needs_crack : instruction produces two uops
//             Macro UOP_CRACK_MUL_EN: MUL becomes MULT + MFLO; otherwise MUL
//             is a single uop with is_result_product set.
//  Revision : 1.0  initial release
// ============================================================================
module uop_decode
    import uop_decode_queue_pkg::*;
(
    input  logic [31:0] i_inst,
    output uop_t        o_uop0,
    output uop_t        o_uop1,
    output logic        o_needs_crack
);
    logic [5:0] w_op, w_fn;
    logic [4:0] w_rs, w_rt, w_rd;

    assign w_op = i_inst[31:26];
    assign w_rs = i_inst[25:21];
    assign w_rt = i_inst[20:16];
    assign w_rd = i_inst[15:11];
    assign w_fn = i_inst[5:0];

    always_comb begin
        o_uop0        = '0;
        o_uop1        = '0;
        o_needs_crack = 1'b0;
        o_uop0.imm    = i_inst[25:0];
        casez (w_op)
            OP_SPECIAL: begin
                o_uop0.dest      = w_rd;
                o_uop0.reg_write = 1'b1;
                o_uop0.src2_sel  = SRC2_RT;
                case (w_fn)
                    FN_ADD:  begin o_uop0.alu_op = ALU_ADD; o_uop0.overflow_en = 1'b1; end
                    FN_ADDU: o_uop0.alu_op = ALU_ADD;
                    FN_SUB:  begin o_uop0.alu_op = ALU_SUB; o_uop0.overflow_en = 1'b1; end
                    FN_SUBU: o_uop0.alu_op = ALU_SUB;
                    FN_AND:  o_uop0.alu_op = ALU_AND;
                    FN_OR:   o_uop0.alu_op = ALU_OR;
                    FN_XOR:  o_uop0.alu_op = ALU_XOR;
                    FN_NOR:  o_uop0.alu_op = ALU_NOR;
                    FN_SLT:  o_uop0.alu_op = ALU_SLT;
                    FN_SLTU: o_uop0.alu_op = ALU_SLTU;
                    FN_SLL:  begin o_uop0.alu_op = ALU_SLL; o_uop0.src1_sel = SRC1_SA; end
                    FN_SRL:  begin o_uop0.alu_op = ALU_SRL; o_uop0.src1_sel = SRC1_SA; end
                    FN_SRA:  begin o_uop0.alu_op = ALU_SRA; o_uop0.src1_sel = SRC1_SA; end
                    FN_SLLV: o_uop0.alu_op = ALU_SLL;
                    FN_SRLV: o_uop0.alu_op = ALU_SRL;
                    FN_SRAV: o_uop0.alu_op = ALU_SRA;
                    FN_JR:   begin o_uop0.is_jr = 1'b1; o_uop0.reg_write = 1'b0; end
                    FN_JALR: begin
                        o_uop0.is_jr    = 1'b1;
                        o_uop0.alu_op   = ALU_ADD;
                        o_uop0.src1_sel = SRC1_PC;
                        o_uop0.src2_sel = SRC2_C8;
                    end
                    FN_MFHI: o_uop0.rd_hi = 1'b1;
                    FN_MFLO: o_uop0.rd_lo = 1'b1;
                    FN_MTHI: begin o_uop0.hi_we = 1'b1; o_uop0.reg_write = 1'b0; end
                    FN_MTLO: begin o_uop0.lo_we = 1'b1; o_uop0.reg_write = 1'b0; end
                    FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                        o_uop0.mul_en    = ~w_fn[1];
                        o_uop0.div_en    = w_fn[1];
                        o_uop0.md_signed = ~w_fn[0];
                        o_uop0.hi_we     = 1'b1;
                        o_uop0.lo_we     = 1'b1;
                        o_uop0.reg_write = 1'b0;
                    end
                    FN_SYSCALL: begin o_uop0.exc_syscall = 1'b1; o_uop0.reg_write = 1'b0; end
                    FN_BREAK:   begin o_uop0.exc_break   = 1'b1; o_uop0.reg_write = 1'b0; end
                    default:    o_uop0.exc_reserved = 1'b1;
                endcase
            end
            OP_REGIMM: begin
                // BLTZ/BGEZ and their linking forms; rt[4] selects the link
                if (w_rt[3:1] == 3'b000) begin
                    o_uop0.is_branch = 1'b1;
                    o_uop0.br_cond   = {2'b10, w_rt[0]};
                    if (w_rt[4]) begin
                        o_uop0.reg_write = 1'b1;
                        o_uop0.dest      = 5'd31;
                        o_uop0.alu_op    = ALU_ADD;
                        o_uop0.src1_sel  = SRC1_PC;
                        o_uop0.src2_sel  = SRC2_C8;
                    end
                end else begin
                    o_uop0.exc_reserved = 1'b1;
                end
            end
            OP_J: o_uop0.is_jump = 1'b1;
            OP_JAL: begin
                o_uop0.is_jump   = 1'b1;
                o_uop0.reg_write = 1'b1;
                o_uop0.dest      = 5'd31;
                o_uop0.alu_op    = ALU_ADD;
                o_uop0.src1_sel  = SRC1_PC;
                o_uop0.src2_sel  = SRC2_C8;
            end
            6'b0001??: begin   // BEQ BNE BLEZ BGTZ
                o_uop0.is_branch = 1'b1;
                o_uop0.br_cond   = {1'b0, w_op[1:0]};
            end
            6'b001???: begin   // immediate ALU ops
                o_uop0.reg_write = 1'b1;
                o_uop0.dest      = w_rt;
                o_uop0.src2_sel  = w_op[2] ? SRC2_ZIMM : SRC2_SIMM;
                case (w_op[2:0])
                    3'b000:  begin o_uop0.alu_op = ALU_ADD; o_uop0.overflow_en = 1'b1; end
                    3'b001:  o_uop0.alu_op = ALU_ADD;
                    3'b010:  o_uop0.alu_op = ALU_SLT;
                    3'b011:  o_uop0.alu_op = ALU_SLTU;
                    3'b100:  o_uop0.alu_op = ALU_AND;
                    3'b101:  o_uop0.alu_op = ALU_OR;
                    3'b110:  o_uop0.alu_op = ALU_XOR;
                    default: o_uop0.alu_op = ALU_LUI;
                endcase
            end
            OP_COP0: begin
                o_uop0.cp0_addr = {w_rd, i_inst[2:0]};
                if (w_rs == 5'b00000) begin
                    o_uop0.cp0_mfc0  = 1'b1;
                    o_uop0.reg_write = 1'b1;
                    o_uop0.dest      = w_rt;
                end else if (w_rs == 5'b00100) begin
                    o_uop0.cp0_mtc0 = 1'b1;
                end else if (w_rs[4]) begin
                    case (w_fn)
                        FN_ERET:  o_uop0.eret  = 1'b1;
                        FN_TLBP:  o_uop0.tlbp  = 1'b1;
                        FN_TLBWI: o_uop0.tlbwi = 1'b1;
                        FN_TLBR:  o_uop0.tlbr  = 1'b1;
                        default:  o_uop0.exc_reserved = 1'b1;
                    endcase
                end else begin
                    o_uop0.exc_reserved = 1'b1;
                end
            end
            OP_SPECIAL2: begin
                if (w_fn == FN_MUL) begin
                    o_uop0.mul_en    = 1'b1;
                    o_uop0.md_signed = 1'b1;
`ifdef UOP_CRACK_MUL_EN
                    o_uop0.hi_we     = 1'b1;
                    o_uop0.lo_we     = 1'b1;
                    o_uop1.rd_lo     = 1'b1;
                    o_uop1.reg_write = 1'b1;
                    o_uop1.dest      = w_rd;
                    o_needs_crack    = 1'b1;
`else
                    o_uop0.is_result_product = 1'b1;
                    o_uop0.reg_write         = 1'b1;
                    o_uop0.dest              = w_rd;
`endif
                end else begin
                    o_uop0.exc_reserved = 1'b1;
                end
            end
            6'b100???, 6'b101???: begin   // loads / stores
                o_uop0.mem_en    = 1'b1;
                o_uop0.mem_wen   = w_op[3];
                o_uop0.reg_write = ~w_op[3];
                o_uop0.dest      = w_rt;
                o_uop0.alu_op    = ALU_ADD;
                o_uop0.src2_sel  = SRC2_SIMM;
                o_uop0.mem_wl    = (w_op[2:0] == 3'b010);
                o_uop0.mem_wr    = (w_op[2:0] == 3'b110);
                // LWL/LWR/SWL/SWR are word accesses with a partial merge
                o_uop0.mem_size  = (w_op[1:0] == 2'b10) ? 2'b11 : w_op[1:0];
                o_uop0.mem_sign  = ~w_op[3] & ~w_op[2] & (w_op[1:0] != 2'b10);
                if (w_op[2:0] == 3'b111 || (w_op[3] && w_op[2:1] == 2'b10))
                    o_uop0.exc_reserved = 1'b1;
            end
            default: o_uop0.exc_reserved = 1'b1;
        endcase

        // A reserved instruction yields a clean single uop with only the flag
        if (o_uop0.exc_reserved) begin
            o_uop0              = '0;
            o_uop0.exc_reserved = 1'b1;
            o_uop1              = '0;
            o_needs_crack       = 1'b0;
        end
        if (!o_uop0.reg_write)
            o_uop0.dest = '0;
    end
endmodule
`default_nettype wire

// File: rtl/uop_decode_queue.sv
`default_nettype none
// ============================================================================
//  Module   : uop_decode_queue
//  Purpose  : ID stage: decodes instructions into uops and buffers them in a
//             DEPTH-entry FIFO between valid/ready handshakes.
//             clk    : clock
//             resetn : asynchronous active-low reset
//             flush  : synchronous flush, overrides both handshakes
//             bus    : uop_decode_queue_if.slave (in_* / out_* handshakes)
//             Macro UOP_CRACK_MUL_EN enables two-uop MUL via the CRACK state.
//  Revision : 1.0  initial release
// ============================================================================
module uop_decode_queue
    import uop_decode_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
)(
    input  logic               clk,
    input  logic               resetn,
    input  logic               flush,
    uop_decode_queue_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        uop_t            uop;
        logic [PC_W-1:0] pc;
        logic            last;
    } entry_t;

    entry_t          r_mem [DEPTH];
    logic [AW-1:0]   r_wptr, r_rptr;
    logic [CW-1:0]   r_count;
    state_t          r_state;
    uop_t            r_pend_uop;
    logic [PC_W-1:0] r_pend_pc;

    uop_t   w_uop0, w_uop1;
    logic   w_crack;
    logic   w_not_full, w_in_ready, w_out_valid;
    logic   w_push_in, w_push_crk, w_push, w_pop;
    entry_t w_wr_entry;

    uop_decode u_decode (
        .i_inst        (bus.in_inst),
        .o_uop0        (w_uop0),
        .o_uop1        (w_uop1),
        .o_needs_crack (w_crack)
    );

    assign w_not_full  = (r_count != CW'(DEPTH));
    assign w_in_ready  = (r_state == ST_IDLE) & w_not_full;
    assign w_out_valid = (r_count != '0);
    assign w_push_in   = bus.in_valid & w_in_ready & ~flush;
    assign w_push_crk  = (r_state == ST_CRACK) & w_not_full & ~flush;
    assign w_push      = w_push_in | w_push_crk;
    assign w_pop       = w_out_valid & bus.out_ready & ~flush;

    always_comb begin
        w_wr_entry = '0;
        if (w_push_crk) begin
            w_wr_entry.uop  = r_pend_uop;
            w_wr_entry.pc   = r_pend_pc;
            w_wr_entry.last = 1'b1;
        end else begin
            w_wr_entry.uop  = w_uop0;
            w_wr_entry.pc   = bus.in_pc;
            w_wr_entry.last = ~w_crack;
        end
    end

    // Storage needs no reset: the output mux hides entries while empty
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wptr] <= w_wr_entry;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= ST_IDLE;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_pend_uop <= '0;
            r_pend_pc  <= '0;
        end else if (flush) begin
            r_state    <= ST_IDLE;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_pend_uop <= '0;
            r_pend_pc  <= '0;
        end else begin
            // DEPTH is a power of two, so natural pointer overflow wraps
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            case (r_state)
                ST_IDLE: begin
                    if (w_push_in && w_crack) begin
                        r_state    <= ST_CRACK;
                        r_pend_uop <= w_uop1;
                        r_pend_pc  <= bus.in_pc;
                    end
                end
                ST_CRACK: begin
                    if (w_push_crk)
                        r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_count = r_count;
    assign bus.out_uop   = w_out_valid ? r_mem[r_rptr].uop  : '0;
    assign bus.out_pc    = w_out_valid ? r_mem[r_rptr].pc   : '0;
    assign bus.out_last  = w_out_valid ? r_mem[r_rptr].last : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_uop_decode_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uop_decode_queue
//  Purpose  : Self-checking bench for uop_decode_queue (DEPTH=4, PC_W=32).
//             Honours UOP_CRACK_MUL_EN for the MUL expectations.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uop_decode_queue;
    import uop_decode_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int PC_W  = 32;
    localparam logic [31:0] I_ADDU = 32'h00221821;
    localparam logic [31:0] I_MUL  = 32'h70A62002;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    logic flush  = 1'b0;

    uop_decode_queue_if #(.DEPTH(DEPTH), .PC_W(PC_W)) bus ();

    uop_decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .flush  (flush),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    uop_t h;
    assign h = bus.out_uop;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // flags = {reg_write, mem_en, mem_wen, overflow_en, syscall, break, reserved}
    typedef struct {
        logic [31:0] inst;
        logic [11:0] alu;
        logic [4:0]  dest;
        logic [6:0]  flags;
    } vec_t;

    vec_t vecs[17];

    function automatic logic [31:0] addiu(input int i);
        logic [4:0] rt;
        rt = 5'((i % 31) + 1);
        return {6'b001001, 5'd0, rt, 16'(i)};
    endfunction

    task automatic push1(input logic [31:0] inst, input logic [31:0] pc);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_inst  = inst;
        bus.in_pc    = pc;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic pop_n(input int n);
        bus.out_ready = 1'b1;
        repeat (n) @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    int tx, rx;

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_inst   = '0;
        bus.in_pc     = '0;
        bus.out_ready = 1'b0;

        vecs[0]  = '{32'h00221821, 12'h001, 5'd3,  7'b1000000}; // ADDU
        vecs[1]  = '{32'h00221820, 12'h001, 5'd3,  7'b1001000}; // ADD
        vecs[2]  = '{32'h00A63823, 12'h002, 5'd7,  7'b1000000}; // SUBU
        vecs[3]  = '{32'h24220005, 12'h001, 5'd2,  7'b1000000}; // ADDIU
        vecs[4]  = '{32'h3C081234, 12'h800, 5'd8,  7'b1000000}; // LUI
        vecs[5]  = '{32'h8D490004, 12'h001, 5'd9,  7'b1100000}; // LW
        vecs[6]  = '{32'hAD490008, 12'h001, 5'd0,  7'b0110000}; // SW
        vecs[7]  = '{32'h0000000C, 12'h000, 5'd0,  7'b0000100}; // SYSCALL
        vecs[8]  = '{32'h0000000D, 12'h000, 5'd0,  7'b0000010}; // BREAK
        vecs[9]  = '{32'hFC000000, 12'h000, 5'd0,  7'b0000001}; // reserved opcode
        vecs[10] = '{32'h0C000010, 12'h001, 5'd31, 7'b1000000}; // JAL
        vecs[11] = '{32'h42000018, 12'h000, 5'd0,  7'b0000000}; // ERET
        vecs[12] = '{32'h40046000, 12'h000, 5'd4,  7'b1000000}; // MFC0
        vecs[13] = '{32'h00031100, 12'h100, 5'd2,  7'b1000000}; // SLL
        vecs[14] = '{32'h0043082A, 12'h004, 5'd1,  7'b1000000}; // SLT
        vecs[15] = '{32'h0000003F, 12'h000, 5'd0,  7'b0000001}; // reserved func
        vecs[16] = '{32'h30C500FF, 12'h010, 5'd5,  7'b1000000}; // ANDI

        // ---------------- reset values ----------------
        #2;
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_count", 32'(bus.out_count), 32'd0);
        chk("rst_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_uop",   32'(bus.out_uop != '0), 32'd0);
        chk("rst_pc",    bus.out_pc, 32'd0);
        chk("rst_last",  32'(bus.out_last), 32'd0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;

        // ---------------- decode table ----------------
        for (int i = 0; i < 17; i++) begin
            push1(vecs[i].inst, 32'h1000 + 32'(4 * i));
            chk("vec_valid", 32'(bus.out_valid), 32'd1);
            chk("vec_count", 32'(bus.out_count), 32'd1);
            chk("vec_alu",   32'(h.alu_op), 32'(vecs[i].alu));
            chk("vec_dest",  32'(h.dest), 32'(vecs[i].dest));
            chk("vec_flags", 32'({h.reg_write, h.mem_en, h.mem_wen, h.overflow_en,
                                  h.exc_syscall, h.exc_break, h.exc_reserved}),
                32'(vecs[i].flags));
            chk("vec_last",  32'(bus.out_last), 32'd1);
            chk("vec_pc",    bus.out_pc, 32'h1000 + 32'(4 * i));
            pop_n(1);
            chk("vec_empty", 32'(bus.out_valid), 32'd0);
            chk("vec_zero_uop", 32'(bus.out_uop != '0), 32'd0);
        end

        // ---------------- MUL ----------------
        push1(I_MUL, 32'h3000);
`ifdef UOP_CRACK_MUL_EN
        chk("mul0_count", 32'(bus.out_count), 32'd1);
        chk("mul0_ready", 32'(bus.in_ready), 32'd0);
        chk("mul0_ctl",   32'({h.mul_en, h.hi_we, h.lo_we, h.reg_write}), 32'b1110);
        chk("mul0_last",  32'(bus.out_last), 32'd0);
        @(negedge clk);
        chk("mul1_count", 32'(bus.out_count), 32'd2);
        chk("mul1_ready", 32'(bus.in_ready), 32'd1);
        pop_n(1);
        chk("mul1_rdlo",  32'({h.rd_lo, h.reg_write}), 32'b11);
        chk("mul1_dest",  32'(h.dest), 32'd4);
        chk("mul1_last",  32'(bus.out_last), 32'd1);
        chk("mul1_pc",    bus.out_pc, 32'h3000);
        pop_n(1);
`else
        chk("mul_count",  32'(bus.out_count), 32'd1);
        chk("mul_ready",  32'(bus.in_ready), 32'd1);
        chk("mul_prod",   32'(h.is_result_product), 32'd1);
        chk("mul_dest",   32'(h.dest), 32'd4);
        chk("mul_rw",     32'(h.reg_write), 32'd1);
        chk("mul_last",   32'(bus.out_last), 32'd1);
        pop_n(1);
`endif
        chk("mul_drained", 32'(bus.out_count), 32'd0);

        // ---------------- full FIFO back-pressure ----------------
        bus.in_inst = I_ADDU;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_pc    = 32'h2000 + 32'(4 * k);
        end
        @(negedge clk);
        bus.in_pc = 32'h2010;
        chk("full_count", 32'(bus.out_count), 32'd4);
        chk("full_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("full_reject", 32'(bus.out_count), 32'd4);
        chk("full_head",   bus.out_pc, 32'h2000);
        pop_n(1);
        chk("pop_count", 32'(bus.out_count), 32'd3);
        chk("pop_ready", 32'(bus.in_ready), 32'd1);
        chk("pop_head",  bus.out_pc, 32'h2004);
        pop_n(3);
        chk("full_drained", 32'(bus.out_count), 32'd0);

        // ---------------- flush during CRACK ----------------
        bus.in_inst = I_ADDU;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_pc    = 32'h5000 + 32'(4 * k);
        end
        @(negedge clk);
        bus.in_inst = I_MUL;
        bus.in_pc   = 32'h500C;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("flush_pre_count", 32'(bus.out_count), 32'd4);
        flush         = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_inst   = I_ADDU;
        bus.out_ready = 1'b1;
        @(negedge clk);
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("flush_count", 32'(bus.out_count), 32'd0);
        chk("flush_valid", 32'(bus.out_valid), 32'd0);
        chk("flush_ready", 32'(bus.in_ready), 32'd1);
        chk("flush_uop",   32'(bus.out_uop != '0), 32'd0);
        @(negedge clk);
        chk("flush_no_uop1", 32'(bus.out_count), 32'd0);

        // flush with a live push and pop in the same cycle: nothing moves
        push1(I_ADDU, 32'h6000);
        flush         = 1'b1;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("flush_hs_count", 32'(bus.out_count), 32'd0);

        // ---------------- streaming with random back-pressure ----------------
        tx = 0;
        rx = 0;
        for (int cyc = 0; cyc < 400 && rx < 20; cyc++) begin
            @(negedge clk);
            bus.in_valid  = (tx < 20);
            bus.in_inst   = addiu(tx);
            bus.in_pc     = 32'h400 + 32'(4 * tx);
            bus.out_ready = 1'($urandom_range(0, 1));
            #1;
            if (bus.out_valid && bus.out_ready) begin
                chk("stream_pc",   bus.out_pc, 32'h400 + 32'(4 * rx));
                chk("stream_dest", 32'(h.dest), 32'((rx % 31) + 1));
                chk("stream_last", 32'(bus.out_last), 32'd1);
                rx++;
            end
            if (bus.in_valid && bus.in_ready)
                tx++;
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("stream_total", 32'(rx), 32'd20);

        // ---------------- asynchronous reset mid-stream ----------------
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_inst  = addiu(k);
            bus.in_pc    = 32'h7000 + 32'(4 * k);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("pre_rst_count", 32'(bus.out_count), 32'd3);
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_count", 32'(bus.out_count), 32'd0);
        chk("arst_ready", 32'(bus.in_ready), 32'd1);
        chk("arst_uop",   32'(bus.out_uop != '0), 32'd0);
        chk("arst_pc",    bus.out_pc, 32'd0);
        chk("arst_last",  32'(bus.out_last), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("post_rst_count", 32'(bus.out_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
`default_nettype wire
